// File: rtl/key_matrix_scanner_if.sv
// Key matrix bundle between the scanner (master) and the keypad/consumer side (slave).
interface key_matrix_scanner_if;
  logic [3:0]  key_row_o;
  logic [3:0]  key_col_i;
  logic        key_valid_o;
  logic [3:0]  key_code_o;
  logic        key_held_o;
  logic [15:0] key_state_o;

  modport master (
    output key_row_o,
    input  key_col_i,
    output key_valid_o,
    output key_code_o,
    output key_held_o,
    output key_state_o
  );

  modport slave (
    input  key_row_o,
    output key_col_i,
    input  key_valid_o,
    input  key_code_o,
    input  key_held_o,
    input  key_state_o
  );
endinterface

// File: rtl/key_matrix_scanner.sv
// 4x4 key matrix scanner: row strobing, frame debounce and press reporting.
// Define KEY_REPEAT_EN to add hold-to-repeat pulses for the last reported key.
module key_matrix_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 5
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DLY   = 125,
  parameter int REPEAT_RATE  = 25
`endif
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  key_matrix_scanner_if.master kbd
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int STAB_W = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]        col_meta_q, col_sync_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        row_q;
  logic [15:0]       raw_q, raw_full, prev_raw_q;
  logic [15:0]       state_q, state_d, new_keys;
  logic [STAB_W-1:0] stable_q, stable_d;
  logic              held_q;
  logic              pend_q, pend_d;
  logic [3:0]        pend_code_q, pend_code_d;
  logic              valid_q;
  logic [3:0]        code_q;
  logic              slot_end, frame_end;

  function automatic logic [3:0] lowest_index(input logic [15:0] v);
    lowest_index = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_index = 4'(i);
    end
  endfunction

  assign slot_end  = (slot_q == SLOT_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (row_q == 2'd3);
  assign slot_d    = slot_end ? '0 : slot_q + SLOT_W'(1);

`ifdef KEY_REPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DLY + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rep_act_q, rep_act_d;
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    raw_full                    = raw_q;
    raw_full[{row_q, 2'b00} +: 4] = ~col_sync_q;
    stable_d                    = stable_q;
    state_d                     = state_q;
    new_keys                    = '0;
    pend_d                      = 1'b0;
    pend_code_d                 = pend_code_q;
`ifdef KEY_REPEAT_EN
    hold_d                      = hold_q;
    rep_act_d                   = rep_act_q;
`endif
    if (frame_end) begin
      if (raw_full == prev_raw_q) begin
        if (stable_q != STAB_W'(DEBOUNCE_CNT)) stable_d = stable_q + STAB_W'(1);
      end else begin
        stable_d = STAB_W'(1);
      end
      if (stable_d == STAB_W'(DEBOUNCE_CNT)) begin
        state_d  = raw_full;
        new_keys = raw_full & ~state_q;
      end
      if (|new_keys) begin
        pend_d      = 1'b1;
        pend_code_d = lowest_index(new_keys);
      end
`ifdef KEY_REPEAT_EN
      // A fresh press restarts the hold timer; releasing the tracked key kills repeats
      // in the same frame because the check uses the map being accepted now.
      if (|new_keys) begin
        hold_d    = '0;
        rep_act_d = 1'b1;
      end else if (rep_act_q) begin
        if (!state_d[code_q]) begin
          rep_act_d = 1'b0;
        end else if ((hold_q + HOLD_W'(1)) == HOLD_W'(REPEAT_DLY)) begin
          pend_d      = 1'b1;
          pend_code_d = code_q;
          hold_d      = HOLD_W'(REPEAT_DLY - REPEAT_RATE);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      col_meta_q  <= 4'hF;
      col_sync_q  <= 4'hF;
      slot_q      <= '0;
      row_q       <= '0;
      raw_q       <= '0;
      prev_raw_q  <= '0;
      stable_q    <= '0;
      state_q     <= '0;
      held_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
      valid_q     <= 1'b0;
      code_q      <= '0;
`ifdef KEY_REPEAT_EN
      hold_q      <= '0;
      rep_act_q   <= 1'b0;
`endif
    end else begin
      col_meta_q  <= kbd.key_col_i;
      col_sync_q  <= col_meta_q;
      slot_q      <= slot_d;
      if (slot_end) begin
        raw_q <= raw_full;
        row_q <= row_q + 2'd1;
      end
      if (frame_end) begin
        prev_raw_q <= raw_full;
        stable_q   <= stable_d;
      end
      state_q     <= state_d;
      held_q      <= |state_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      valid_q     <= pend_q;
      if (pend_q) code_q <= pend_code_q;
`ifdef KEY_REPEAT_EN
      hold_q      <= hold_d;
      rep_act_q   <= rep_act_d;
`endif
    end
  end

  assign kbd.key_row_o   = ~(4'b0001 << row_q);
  assign kbd.key_valid_o = valid_q;
  assign kbd.key_code_o  = code_q;
  assign kbd.key_held_o  = held_q;
  assign kbd.key_state_o = state_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner; columns are modelled from a pressed-key map.
module tb_key_matrix_scanner;

  localparam int FRAME = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0]  col_drv;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  int cyc = 0;
  int chg_cyc = 0;
  int last_lat = -1;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_state = '0;

  key_matrix_scanner_if kbd ();

  key_matrix_scanner #(
    .SCAN_DIV(8),
    .DEBOUNCE_CNT(3)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DLY(4),
    .REPEAT_RATE(2)
`endif
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .kbd(kbd)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kbd.key_row_o[r] && pressed[r*4+c]) col_drv[c] = 1'b0;
  end
  assign kbd.key_col_i = col_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (kbd.key_valid_o) begin
      pulse_cnt++;
      last_lat = cyc - chg_cyc;
      check("pulse_width", 32'(prev_valid), 32'd0);
    end
    if (kbd.key_state_o != prev_state) chg_cyc = cyc;
    prev_state = kbd.key_state_o;
    prev_valid = kbd.key_valid_o;
  end

  // Wait for the edge where row 0 is re-driven, i.e. the start of a frame.
  task automatic align();
    logic [3:0] r_prev;
    bit found;
    found  = 1'b0;
    r_prev = kbd.key_row_o;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (kbd.key_row_o == 4'b1110 && r_prev == 4'b0111) found = 1'b1;
      r_prev = kbd.key_row_o;
    end
    if (!found) check("align_timeout", 32'd0, 32'd1);
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] map;
    logic [15:0] exp_state;
    int          exp_pulses;
    logic [3:0]  exp_code;
    bit          chk_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0;
    int exp_rep;

    vecs[0] = '{16'h0040, 16'h0040, 1, 4'd6,  1'b1};
    vecs[1] = '{16'h0000, 16'h0000, 0, 4'd6,  1'b0};
    vecs[2] = '{16'h1008, 16'h1008, 1, 4'd3,  1'b1};
    vecs[3] = '{16'h1000, 16'h1000, 0, 4'd3,  1'b0};
    vecs[4] = '{16'h1008, 16'h1008, 1, 4'd3,  1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 0, 4'd3,  1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1, 4'd15, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 0, 4'd15, 1'b0};

    // Reset state and first row rotation
    repeat (3) @(negedge clk);
    check("rst_row",   32'(kbd.key_row_o),   32'h0000000E);
    check("rst_valid", 32'(kbd.key_valid_o), 32'd0);
    check("rst_code",  32'(kbd.key_code_o),  32'd0);
    check("rst_held",  32'(kbd.key_held_o),  32'd0);
    check("rst_state", 32'(kbd.key_state_o), 32'd0);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    check("row_before_rotate", 32'(kbd.key_row_o), 32'h0000000E);
    @(negedge clk);
    check("row_after_rotate",  32'(kbd.key_row_o), 32'h0000000D);

    // Table: clean presses, releases, simultaneous keys, index 15
    for (int i = 0; i < 8; i++) begin
      align();
      pressed = vecs[i].map;
      p0 = pulse_cnt;
      frames(4);
      check($sformatf("v%0d_state", i),  32'(kbd.key_state_o), 32'(vecs[i].exp_state));
      check($sformatf("v%0d_held", i),   32'(kbd.key_held_o),  32'(|vecs[i].exp_state));
      check($sformatf("v%0d_pulses", i), 32'(pulse_cnt - p0),  32'(vecs[i].exp_pulses));
      check($sformatf("v%0d_code", i),   32'(kbd.key_code_o),  32'(vecs[i].exp_code));
      if (vecs[i].chk_lat) check($sformatf("v%0d_latency", i), 32'(last_lat), 32'd1);
    end

    // Key 9 bouncing for 4 frames, then stable
    align();
    p0 = pulse_cnt;
    for (int f = 0; f < 4; f++) begin
      pressed = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      frames(1);
    end
    check("bounce_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    pressed = 16'h0200;
    frames(2);
    check("bounce_2_stable", 32'(pulse_cnt - p0), 32'd0);
    frames(2);
    check("bounce_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("bounce_code",   32'(kbd.key_code_o), 32'd9);
    check("bounce_state",  32'(kbd.key_state_o), 32'h00000200);
    pressed = 16'h0000;
    frames(4);

    // Reset mid-slot while key 5 is debounced and held
    align();
    pressed = 16'h0020;
    p0 = pulse_cnt;
    frames(4);
    check("k5_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("k5_state",  32'(kbd.key_state_o), 32'h00000020);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    p0 = pulse_cnt;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_state", 32'(kbd.key_state_o), 32'd0);
    check("mrst_held",  32'(kbd.key_held_o),  32'd0);
    check("mrst_valid", 32'(kbd.key_valid_o), 32'd0);
    check("mrst_code",  32'(kbd.key_code_o),  32'd0);
    check("mrst_row",   32'(kbd.key_row_o),   32'h0000000E);
    repeat (2 * FRAME) @(negedge clk);
    check("mrst_no_early_pulse", 32'(pulse_cnt - p0), 32'd0);
    repeat (40) @(negedge clk);
    check("mrst_repulse", 32'(pulse_cnt - p0), 32'd1);
    check("mrst_code5",   32'(kbd.key_code_o), 32'd5);
    check("mrst_state5",  32'(kbd.key_state_o), 32'h00000020);
    pressed = 16'h0000;
    frames(4);
    check("mrst_release", 32'(kbd.key_state_o), 32'd0);

    // Hold key 0 long enough for auto-repeat, then release
`ifdef KEY_REPEAT_EN
    exp_rep = 5;
`else
    exp_rep = 1;
`endif
    align();
    pressed = 16'h0001;
    p0 = pulse_cnt;
    frames(14);
    check("hold_pulses", 32'(pulse_cnt - p0), 32'(exp_rep));
    check("hold_code",   32'(kbd.key_code_o), 32'd0);
    pressed = 16'h0000;
    p0 = pulse_cnt;
    frames(6);
    check("hold_release_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("hold_release_state",  32'(kbd.key_state_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
